// File: rtl/inst_buffer_if.sv
// Fetch-to-decode instruction buffer bundle: fetch push slots, decode pop controls, buffer status.
// The buffer side uses the slave modport; the fetch/decode side uses master.
`ifndef DUAL_ISSUE
`define DUAL_ISSUE 1'b1
`endif
`ifndef SINGLE_ISSUE
`define SINGLE_ISSUE 1'b0
`endif

interface inst_buffer_if #(parameter int DEPTH = 16);
   logic                     flush;
   logic                     fetch_valid1;
   logic                     fetch_valid2;
   logic [31:0]              fetch_inst1;
   logic [31:0]              fetch_inst2;
   logic [31:0]              fetch_iaddr1;
   logic [31:0]              fetch_iaddr2;
   logic                     instBuffer_re;
   logic                     issue_mode;
   logic [31:0]              inst1;
   logic [31:0]              inst2;
   logic [31:0]              iaddr1;
   logic [31:0]              iaddr2;
   logic                     inst1_valid;
   logic                     inst2_valid;
   logic                     ibuf_full;
   logic [$clog2(DEPTH):0]   ibuf_count;

   modport master (
      output flush, fetch_valid1, fetch_valid2, fetch_inst1, fetch_inst2,
             fetch_iaddr1, fetch_iaddr2, instBuffer_re, issue_mode,
      input  inst1, inst2, iaddr1, iaddr2, inst1_valid, inst2_valid,
             ibuf_full, ibuf_count
   );

   modport slave (
      input  flush, fetch_valid1, fetch_valid2, fetch_inst1, fetch_inst2,
             fetch_iaddr1, fetch_iaddr2, instBuffer_re, issue_mode,
      output inst1, inst2, iaddr1, iaddr2, inst1_valid, inst2_valid,
             ibuf_full, ibuf_count
   );
endinterface

// File: rtl/inst_buffer.sv
// Circular instruction FIFO, up to 2 pushes and 2 pops per cycle; entries visible 1 cycle after push.
// Backpressure: ibuf_full when fewer than 2 slots free; pushes while full are dropped, flush wins over all.
`ifndef DUAL_ISSUE
`define DUAL_ISSUE 1'b1
`endif

module inst_buffer #(
   parameter int DEPTH = 16
) (
   input  logic          clk,
   input  logic          resetn,
   inst_buffer_if.slave  bus
);
   localparam int AW = $clog2(DEPTH);

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] iaddr;
   } ent_t;

   ent_t          mem [DEPTH];
   logic [AW-1:0] head;
   logic [AW-1:0] tail;
   logic [AW:0]   count;
   logic [1:0]    push_cnt;
   logic [1:0]    pop_cnt;
   logic          full;
   logic          v1;
   logic          v2;
   logic [AW-1:0] head1;

   assign full  = count > (AW+1)'(DEPTH - 2);
   assign v1    = count >= (AW+1)'(1);
   assign v2    = count >= (AW+1)'(2);
   assign head1 = head + AW'(1);

   always_comb begin
      push_cnt = 2'd0;
      pop_cnt  = 2'd0;
      if (!bus.flush && !full)
         push_cnt = {1'b0, bus.fetch_valid1} + {1'b0, bus.fetch_valid1 & bus.fetch_valid2};
      if (!bus.flush && bus.instBuffer_re && v1)
         pop_cnt = (bus.issue_mode == `DUAL_ISSUE && v2) ? 2'd2 : 2'd1;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (bus.flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         head  <= head + AW'(pop_cnt);
         tail  <= tail + AW'(push_cnt);
         count <= count + (AW+1)'(push_cnt) - (AW+1)'(pop_cnt);
      end
   end

   // Storage is never cleared; stale slots are hidden by the valid/zeroing rule.
   always_ff @(posedge clk) begin
      if (push_cnt != 2'd0)
         mem[tail] <= '{inst: bus.fetch_inst1, iaddr: bus.fetch_iaddr1};
      if (push_cnt == 2'd2)
         mem[tail + AW'(1)] <= '{inst: bus.fetch_inst2, iaddr: bus.fetch_iaddr2};
   end

   assign bus.inst1       = v1 ? mem[head].inst   : 32'h0;
   assign bus.iaddr1      = v1 ? mem[head].iaddr  : 32'h0;
   assign bus.inst2       = v2 ? mem[head1].inst  : 32'h0;
   assign bus.iaddr2      = v2 ? mem[head1].iaddr : 32'h0;
   assign bus.inst1_valid = v1;
   assign bus.inst2_valid = v2;
   assign bus.ibuf_full   = full;
   assign bus.ibuf_count  = count;
endmodule

// File: doc/inst_buffer.md
INST_BUFFER -- requirements
Module: inst_buffer

Interface
REQ-001 Parameter DEPTH, default 16, number of entries; power of two, minimum 4.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 resetn  input  1  reset, asynchronous, active-low.
REQ-004 flush  input  1  discard all entries (exception/branch redirect).
REQ-005 fetch_valid1  input  1  fetch slot 1 carries an instruction.
REQ-006 fetch_valid2  input  1  fetch slot 2 carries an instruction; only legal with fetch_valid1=1.
REQ-007 fetch_inst1, fetch_inst2  input  32 each  fetched instruction words.
REQ-008 fetch_iaddr1, fetch_iaddr2  input  32 each  PCs of the fetched words.
REQ-009 instBuffer_re  input  1  decode consumes this cycle.
REQ-010 issue_mode  input  1  `DUAL_ISSUE or `SINGLE_ISSUE, the decode stage's pairing decision.
REQ-011 inst1, inst2  output  32 each  head and head+1 instruction words to decode.
REQ-012 iaddr1, iaddr2  output  32 each  head and head+1 PCs.
REQ-013 inst1_valid, inst2_valid  output  1 each  head / head+1 entries present.
REQ-014 ibuf_full  output  1  fewer than 2 free entries; fetch must hold.
REQ-015 ibuf_count  output  log2(DEPTH)+1  occupied entries.

Function
REQ-016 Storage is a circular FIFO of DEPTH entries, each holding {inst[31:0], iaddr[31:0]}, with head and tail pointers of log2(DEPTH) bits that wrap modulo DEPTH.
REQ-017 ibuf_count is registered; inst1_valid = (count>=1) and inst2_valid = (count>=2), both decoded from the registered count.
REQ-018 inst1/iaddr1 read the entry at head, and inst2/iaddr2 read the entry at head+1 mod DEPTH; any slot whose valid is 0 drives 32'h0 on both fields.
REQ-019 ibuf_full = (count > DEPTH-2), computed from the registered count.
REQ-020 Push count = 0 if ibuf_full or flush; otherwise fetch_valid1 + (fetch_valid1 & fetch_valid2).
  - Slot 1 is written at tail; slot 2 is written at tail+1.
  - tail advances by the push count.
  - When ibuf_full=1, pushes are dropped silently with no overwrite.
REQ-021 Pop count = 0 if flush or !instBuffer_re or !inst1_valid.
  - Pop count = 2 if issue_mode==`DUAL_ISSUE and inst2_valid.
  - Pop count = 1 otherwise.
  - head advances by the pop count.
REQ-022 Simultaneous push and pop in one cycle: count_next = count + push - pop.
  - Acceptance is based on the pre-pop count, which is conservative.
  - The count never exceeds DEPTH and never underflows.
REQ-023 Latency: a pushed entry becomes visible on the outputs the cycle after its push edge; there is no write-to-read bypass.
REQ-024 Order preservation: instructions leave in the exact order they entered, including across pointer wrap-around.
REQ-025 Flush has highest priority: on the flush edge head, tail and count go to 0, and same-cycle push and pop are ignored.
REQ-026 The storage array is not cleared by flush or reset; correctness relies only on the valid and zeroing rules.
REQ-027 instBuffer_re with inst1_valid=0 has no effect.

Reset
REQ-028 While resetn=0, asynchronously:
  - head=0, tail=0, count=0;
  - inst1_valid=0, inst2_valid=0, ibuf_full=0;
  - inst1, inst2, iaddr1, iaddr2 = 32'h0.
REQ-029 Reset asserted mid-operation discards all contents immediately.
  - The first edge after deassertion behaves as an empty buffer.

Verification
REQ-030 Reset with stale contents.
  - Stimulus: resetn=0 while count=7.
  - Response: count=0, valids=0 and outputs=0 within the same cycle, without waiting for a clock edge.
REQ-031 Dual push and dual pop.
  - Stimulus: push 0x24010001@0xBFC00000 and 0x24020002@0xBFC00004.
  - Response next cycle: inst1=0x24010001, iaddr2=0xBFC00004, both valid, count=2.
  - Stimulus: re=1 with `DUAL_ISSUE.
  - Response next cycle: count=0, valids=0.
REQ-032 Single issue.
  - Stimulus: count=2 (A,B); re=1 with `SINGLE_ISSUE.
  - Response: next cycle inst1=B, inst2_valid=0, count=1.
REQ-033 Full condition.
  - Stimulus: fill to count=15, then keep pushing 2 per cycle.
  - Response: ibuf_full=1; pushes are dropped and count stays 15.
  - Stimulus: one `DUAL_ISSUE pop while pushing 2.
  - Response: count=13, because acceptance uses the pre-pop count.
REQ-034 Wrap-around and ordering.
  - Stimulus: 40 push-2 / pop-random cycles with incrementing PCs.
  - Response: a scoreboard sees PCs strictly in order across pointer wrap.
REQ-035 Flush priority.
  - Stimulus: flush=1 together with push 2 and re=1 at count=9.
  - Response: next cycle count=0 and valids=0; the pushed words are never observed.
